// File: rtl/bmem_pkg.sv
// Shared constants and types for the cacheline-to-bmem burst adapter.
package bmem_pkg;
  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned BEAT_BITS   = 64;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;

  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [LINE_BITS-1:0] wdata;
  } bmem_line_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } issue_state_e;
endpackage

// File: rtl/bmem_read_tracker.sv
// Outstanding-read table: lowest-free allocation, free-by-line-address,
// hazard lookup and occupancy count.
module bmem_read_tracker
  import bmem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc,
  input  logic [TAG_BITS-1:0] alloc_tag,
  input  logic                free,
  input  logic [TAG_BITS-1:0] free_tag,
  input  logic [TAG_BITS-1:0] match_tag,
  output logic                free_hit,
  output logic                match_hit,
  output logic [CNT_W-1:0]    count
);
  localparam int unsigned IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [MAX_OUTSTANDING-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0]        tag_q [MAX_OUTSTANDING];
  logic [TAG_BITS-1:0]        tag_d [MAX_OUTSTANDING];
  logic [CNT_W-1:0]           count_q, count_d;
  logic [IDX_W-1:0]           free_idx, alloc_idx;
  logic                       alloc_found;

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    free_hit    = 1'b0;
    match_hit   = 1'b0;
    free_idx    = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (valid_q[i] && tag_q[i] == match_tag) match_hit = 1'b1;
      if (valid_q[i] && tag_q[i] == free_tag && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
    // Freed slot was valid in the registered view, so it can never collide with the alloc slot.
    if (free && free_hit) valid_d[free_idx] = 1'b0;
    if (alloc && alloc_found) begin
      valid_d[alloc_idx] = 1'b1;
      tag_d[alloc_idx]   = alloc_tag;
    end
    count_d = count_q + CNT_W'(alloc && alloc_found) - CNT_W'(free && free_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/bmem_line_adapter.sv
// Cacheline request adapter: issues 4-beat bmem bursts and reassembles
// returning read bursts into line responses.
module bmem_line_adapter
  import bmem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [255:0] req_wdata,
  output logic         resp_valid,
  output logic [31:0]  resp_addr,
  output logic [255:0] resp_rdata,
  output logic         wr_done,
  output logic         err,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  issue_state_e                    state_q, state_d;
  logic [1:0]                      wr_beat_q, wr_beat_d;
  logic [TAG_BITS-1:0]             wr_tag_q, wr_tag_d;
  logic [BEATS-1:0][BEAT_BITS-1:0] wr_data_q, wr_data_d;
  logic                            wr_done_q, wr_done_d;
  logic [1:0]                      rx_beat_q, rx_beat_d;
  logic [TAG_BITS-1:0]             rx_tag_q, rx_tag_d;
  logic                            rx_drop_q, rx_drop_d;
  logic [2:0][BEAT_BITS-1:0]       rx_data_q, rx_data_d;
  logic                            resp_valid_q, resp_valid_d;
  logic [TAG_BITS-1:0]             resp_tag_q, resp_tag_d;
  logic [LINE_BITS-1:0]            resp_data_q, resp_data_d;
  logic                            err_q, err_d;

  bmem_line_req_t   req;
  logic             accept, alloc, free, free_hit, hazard;
  logic [CNT_W-1:0] count;
  logic             unused_low_bits;

  assign req             = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign unused_low_bits = ^{req.addr[OFFSET_BITS-1:0], bmem_raddr[OFFSET_BITS-1:0]};

  bmem_read_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .alloc     (alloc),
    .alloc_tag (req.addr[31:OFFSET_BITS]),
    .free      (free),
    .free_tag  (rx_tag_q),
    .match_tag (req.addr[31:OFFSET_BITS]),
    .free_hit  (free_hit),
    .match_hit (hazard),
    .count     (count)
  );

  always_comb begin
    req_ready = 1'b0;
    if (!rst && state_q == ST_IDLE && bmem_ready)
      req_ready = req.we ? !hazard : (count < CNT_W'(MAX_OUTSTANDING));
  end

  assign accept = req_valid && req_ready;
  assign alloc  = accept && !req.we;

  always_comb begin
    state_d   = state_q;
    wr_beat_d = wr_beat_q;
    wr_tag_d  = wr_tag_q;
    wr_data_d = wr_data_q;
    wr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && req.we) begin
          state_d   = ST_WRITE;
          wr_beat_d = 2'd1;
          wr_tag_d  = req.addr[31:OFFSET_BITS];
          wr_data_d = req.wdata;
        end
      end
      ST_WRITE: begin
        if (bmem_ready) begin
          wr_beat_d = wr_beat_q + 2'd1;
          if (wr_beat_q == 2'd3) begin
            state_d   = ST_IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bmem_addr = {req.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            if (req.we) begin
              bmem_write = 1'b1;
              bmem_wdata = req.wdata[BEAT_BITS-1:0];
            end else begin
              bmem_read = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          bmem_addr  = {wr_tag_q, {OFFSET_BITS{1'b0}}};
          bmem_wdata = wr_data_q[wr_beat_q];
          bmem_write = bmem_ready;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx_beat_d    = rx_beat_q;
    rx_tag_d     = rx_tag_q;
    rx_drop_d    = rx_drop_q;
    rx_data_d    = rx_data_q;
    resp_valid_d = 1'b0;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    free         = 1'b0;
    if (bmem_rvalid) begin
      rx_beat_d = rx_beat_q + 2'd1;
      if (rx_beat_q == 2'd0) begin
        rx_tag_d  = bmem_raddr[31:OFFSET_BITS];
        rx_drop_d = 1'b0;
      end else if (bmem_raddr[31:OFFSET_BITS] != rx_tag_q) begin
        rx_drop_d = 1'b1;
        err_d     = 1'b1;
      end
      case (rx_beat_q)
        2'd0: rx_data_d[0] = bmem_rdata;
        2'd1: rx_data_d[1] = bmem_rdata;
        2'd2: rx_data_d[2] = bmem_rdata;
        default: ;
      endcase
      // A burst already marked bad is dropped without touching the tracker.
      if (rx_beat_q == 2'd3 && !rx_drop_q && bmem_raddr[31:OFFSET_BITS] == rx_tag_q) begin
        free = 1'b1;
        if (free_hit) begin
          resp_valid_d = 1'b1;
          resp_tag_d   = rx_tag_q;
          resp_data_d  = {bmem_rdata, rx_data_q};
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_beat_q <= '0;
      wr_tag_q  <= '0;
      wr_data_q <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_beat_q <= wr_beat_d;
      wr_tag_q  <= wr_tag_d;
      wr_data_q <= wr_data_d;
      wr_done_q <= wr_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_beat_q    <= '0;
      rx_tag_q     <= '0;
      rx_drop_q    <= 1'b0;
      rx_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rx_beat_q    <= rx_beat_d;
      rx_tag_q     <= rx_tag_d;
      rx_drop_q    <= rx_drop_d;
      rx_data_q    <= rx_data_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_addr  = {resp_tag_q, {OFFSET_BITS{1'b0}}};
  assign resp_rdata = resp_data_q;
  assign wr_done    = wr_done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_bmem_line_adapter.sv
// Randomized + directed bench for bmem_line_adapter against a queue-based line-level model.
`timescale 1ns/1ps
module tb_bmem_line_adapter;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_we;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [255:0] req_wdata;
  logic         resp_valid, wr_done, err;
  logic [31:0]  resp_addr;
  logic [255:0] resp_rdata;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr  = '0;
  logic [63:0]  bmem_rdata  = '0;
  logic         bmem_rvalid = 1'b0;

  always #5 clk = ~clk;

  bmem_line_adapter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_rdata(resp_rdata),
    .wr_done(wr_done), .err(err),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int unsigned n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a, input int k);
    return {a, 32'hB0B0_0000 | 32'(k)};
  endfunction

  // Line-level model: outstanding reads as a list of line addresses.
  logic [31:0]  outq[$];
  int           wr_left = 0, wr_idx = 0;
  logic [255:0] wr_line;
  logic [31:0]  wr_addr;
  logic         m_wr_done = 0, m_resp_v = 0, m_err = 0;
  logic [31:0]  m_resp_addr = 0;
  logic [255:0] m_resp_data = 0;
  int           rx_idx = 0;
  logic [31:0]  rx_addr;
  logic         rx_bad;
  logic [63:0]  rx_w [4];

  logic [31:0]  cmdq[$];
  logic [31:0]  resp_log[$];
  logic [63:0]  wq[$];
  int           resp_cnt = 0, wr_done_cnt = 0;
  logic [255:0] last_resp_data;
  logic         acc_last = 0;

  logic         exp_rdy, exp_acc, exp_rd, exp_wr, hz, found;
  int           fidx;

  always @(negedge clk) begin
    acc_last = req_valid && req_ready;
    if (bmem_read) cmdq.push_back(bmem_addr);
    if (resp_valid) begin
      resp_log.push_back(resp_addr);
      last_resp_data = resp_rdata;
      resp_cnt++;
    end
    if (bmem_write) wq.push_back(bmem_wdata);
    if (wr_done) wr_done_cnt++;

    chk("resp_valid", resp_valid, m_resp_v);
    if (m_resp_v) begin
      chk("resp_addr", resp_addr, m_resp_addr);
      chk("resp_rdata", resp_rdata, m_resp_data);
    end
    chk("wr_done", wr_done, m_wr_done);
    chk("err", err, m_err);

    if (rst) begin
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_bmem_read", bmem_read, 1'b0);
      chk("rst_bmem_write", bmem_write, 1'b0);
      chk("rst_bmem_addr", bmem_addr, 32'h0);
      chk("rst_bmem_wdata", bmem_wdata, 64'h0);
      outq.delete();
      wr_left = 0; wr_idx = 0;
      m_wr_done = 0; m_resp_v = 0; m_err = 0; m_resp_addr = 0; m_resp_data = 0;
      rx_idx = 0;
    end else begin
      hz = 0;
      foreach (outq[i]) if (outq[i] == line_of(req_addr)) hz = 1;
      exp_rdy = (wr_left == 0) && bmem_ready && (req_we ? !hz : (outq.size() < 4));
      chk("req_ready", req_ready, exp_rdy);
      exp_acc = req_valid && exp_rdy;
      exp_rd  = exp_acc && !req_we;
      exp_wr  = (exp_acc && req_we) || (wr_left > 0 && bmem_ready);
      chk("bmem_read", bmem_read, exp_rd);
      chk("bmem_write", bmem_write, exp_wr);
      if (exp_acc) chk("bmem_addr", bmem_addr, line_of(req_addr));
      else if (exp_wr) chk("bmem_addr", bmem_addr, wr_addr);
      if (exp_acc && req_we) chk("bmem_wdata", bmem_wdata, req_wdata[63:0]);
      else if (exp_wr) chk("bmem_wdata", bmem_wdata, wr_line[64*wr_idx +: 64]);

      m_wr_done = 0;
      m_resp_v  = 0;
      if (bmem_rvalid) begin
        if (rx_idx == 0) begin
          rx_addr = bmem_raddr;
          rx_bad  = 0;
        end else if (bmem_raddr[31:5] != rx_addr[31:5]) begin
          rx_bad = 1;
          m_err  = 1;
        end
        rx_w[rx_idx] = bmem_rdata;
        if (rx_idx == 3 && !rx_bad) begin
          found = 0; fidx = 0;
          foreach (outq[i]) if (!found && outq[i] == line_of(rx_addr)) begin found = 1; fidx = i; end
          if (found) begin
            outq.delete(fidx);
            m_resp_v    = 1;
            m_resp_addr = line_of(rx_addr);
            m_resp_data = {rx_w[3], rx_w[2], rx_w[1], rx_w[0]};
          end else begin
            m_err = 1;
          end
        end
        rx_idx = (rx_idx + 1) % 4;
      end
      if (exp_rd) outq.push_back(line_of(req_addr));
      if (exp_acc && req_we) begin
        wr_left = 3; wr_idx = 1; wr_line = req_wdata; wr_addr = line_of(req_addr);
      end else if (wr_left > 0 && bmem_ready) begin
        wr_idx++; wr_left--;
        if (wr_left == 0) m_wr_done = 1;
      end
    end
  end

  // Memory responder: returns bursts queued in retq, or picks issued reads at random.
  logic        auto_ret = 0;
  logic [31:0] retq[$];
  int          corrupt_beat = -1, cur_cb = -1, rb = 0, pick;
  logic        active = 0;
  logic [31:0] cur;

  always @(posedge clk) begin
    #1;
    bmem_rvalid = 1'b0;
    if (!active) begin
      if (auto_ret && cmdq.size() > 0 && $urandom_range(0, 3) == 0) begin
        pick = $urandom_range(0, cmdq.size() - 1);
        retq.push_back(cmdq[pick]);
        cmdq.delete(pick);
      end
      if (retq.size() > 0) begin
        cur = retq.pop_front(); cur_cb = corrupt_beat; corrupt_beat = -1; rb = 0; active = 1;
      end
    end
    if (active) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = (rb == cur_cb) ? cur + 32'h100 : cur;
      bmem_rdata  = mem_word(cur, rb);
      rb++;
      if (rb == 4) active = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [255:0] d, input int maxc);
    int c = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    do begin tick(); c++; end while (!acc_last && c < maxc);
    req_valid = 0;
    chk("accept_timeout", acc_last, 1'b1);
  endtask

  task automatic wait_resp(input int n, input int maxc);
    int c = 0;
    while (resp_cnt < n && c < maxc) begin tick(); c++; end
    chk("resp_timeout", resp_cnt >= n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;
  logic [31:0] exp_order [5];

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; bmem_ready = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    // Single read with hand-computed line
    do_req(0, 32'h0000_1040, '0, 10);
    chk("single_cmd_count", cmdq.size(), 1);
    chk("single_cmd_addr", cmdq[0], 32'h0000_1040);
    cmdq.delete();
    retq.push_back(32'h0000_1040);
    wait_resp(1, 50);
    chk("single_resp_addr", resp_log[0], 32'h0000_1040);
    chk("single_resp_data", last_resp_data,
        256'h00001040B0B00003_00001040B0B00002_00001040B0B00001_00001040B0B00000);

    // Four back-to-back reads, fifth blocked, out-of-order returns
    resp_cnt = 0; resp_log.delete();
    for (int i = 0; i < 4; i++) do_req(0, 32'h5000 + 32'(i * 32) + 32'(i), '0, 10);
    req_valid = 1; req_we = 0; req_addr = 32'h5080;
    repeat (3) begin tick(); chk("fifth_blocked", acc_last, 1'b0); end
    cmdq.delete();
    retq.push_back(32'h5060); retq.push_back(32'h5000);
    retq.push_back(32'h5040); retq.push_back(32'h5020);
    begin
      int c = 0;
      while (!acc_last && c < 60) begin tick(); c++; end
    end
    req_valid = 0;
    chk("fifth_accept", acc_last, 1'b1);
    chk("fifth_after_first_resp", resp_cnt, 1);
    cmdq.delete();
    retq.push_back(32'h5080);
    wait_resp(5, 100);
    exp_order = '{32'h5060, 32'h5000, 32'h5040, 32'h5020, 32'h5080};
    for (int i = 0; i < 5; i++) chk("resp_order", resp_log[i], exp_order[i]);

    // Write with two stall cycles
    wq.delete(); wr_done_cnt = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h2000;
    req_wdata = {64'd3, 64'd2, 64'd1, 64'd0}; bmem_ready = 1;
    tick();
    chk("write_accept", acc_last, 1'b1);
    req_valid = 0; bmem_ready = 0;
    repeat (2) tick();
    bmem_ready = 1;
    repeat (5) tick();
    chk("write_beats", wq.size(), 4);
    for (int k = 0; k < 4; k++) chk("write_word", wq[k], 64'(k));
    chk("write_done_once", wr_done_cnt, 1);

    // Write-after-read hazard
    do_req(0, 32'h3000, '0, 10);
    base = resp_cnt;
    req_valid = 1; req_we = 1; req_addr = 32'h3004; req_wdata = {8{32'h1234_5678}};
    repeat (4) begin tick(); chk("hazard_blocked", acc_last, 1'b0); end
    cmdq.delete();
    retq.push_back(32'h3000);
    begin
      int c = 0;
      while (!acc_last && c < 60) begin tick(); c++; end
    end
    req_valid = 0;
    chk("hazard_accept", acc_last, 1'b1);
    chk("hazard_after_resp", resp_cnt, base + 1);
    repeat (6) tick();

    // Randomized traffic
    auto_ret = 1;
    for (int n = 0; n < 800; n++) begin
      tick();
      bmem_ready = ($urandom_range(0, 4) != 0);
      if (acc_last) req_valid = 0;
      if (!req_valid && $urandom_range(0, 2) == 0) begin
        req_valid = 1;
        req_we    = ($urandom_range(0, 2) == 0);
        req_addr  = 32'h4000 + 32'($urandom_range(0, 5) * 32) + 32'($urandom_range(0, 31));
        req_wdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    tick();
    req_valid = 0; bmem_ready = 1;
    begin
      int c = 0;
      while ((outq.size() != 0 || active || retq.size() != 0 || cmdq.size() != 0) && c < 3000) begin
        tick(); c++;
      end
      chk("drain_timeout", c < 3000, 1'b1);
    end
    repeat (8) tick();
    auto_ret = 0;
    cmdq.delete();

    // Address change mid-burst
    base = resp_cnt;
    do_req(0, 32'h6000, '0, 10);
    cmdq.delete();
    corrupt_beat = 2;
    retq.push_back(32'h6000);
    repeat (8) tick();
    chk("corrupt_err", err, 1'b1);
    chk("corrupt_no_resp", resp_cnt, base);
    repeat (5) tick();
    chk("err_sticky", err, 1'b1);

    // Reset during write beat 2
    wr_done_cnt = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h7000; req_wdata = {8{32'hCAFE_F00D}}; bmem_ready = 1;
    tick();
    chk("rst_write_accept", acc_last, 1'b1);
    req_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    repeat (6) tick();
    chk("rst_no_wr_done", wr_done_cnt, 0);
    chk("rst_err_cleared", err, 1'b0);

    // Burst for a line never requested
    base = resp_cnt;
    retq.push_back(32'h7700);
    repeat (8) tick();
    chk("miss_err", err, 1'b1);
    chk("miss_no_resp", resp_cnt, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
